// File: rtl/multi_chan_fetch_if.sv
// Handshake bundle for multi_chan_fetch: memory-side fetch port plus per-channel output port.
// The master modport is the fetch block; slave is the surrounding memory/consumer side.
interface multi_chan_fetch_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 17,
    parameter int unsigned NUM_CH = 3
);
    logic [DATA_W-1:0] in_data;
    logic              in_rts;
    logic              in_rtr;
    logic [ADDR_W-1:0] mem_ptr;
    logic [DATA_W-1:0] out_data;
    logic [NUM_CH-1:0] out_rts;
    logic [NUM_CH-1:0] out_rtr;

    modport master (
        input  in_data, in_rts, out_rtr,
        output in_rtr, mem_ptr, out_data, out_rts
    );

    modport slave (
        output in_data, in_rts, out_rtr,
        input  in_rtr, mem_ptr, out_data, out_rts
    );
endinterface

// File: rtl/multi_chan_fetch.sv
// Frame fetch unit: streams FRAME_WORDS words from memory through a small FIFO and
// deals them round-robin to NUM_CH channels, with restart-on-enable and frame_done status.
module multi_chan_fetch #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 17,
    parameter int unsigned NUM_CH      = 3,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned FRAME_WORDS = 76800
) (
    input  logic                 clk,
    input  logic                 rst_,
    input  logic                 en,
    multi_chan_fetch_if.master   bus,
    output logic                 busy,
    output logic                 frame_done
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(FRAME_WORDS - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [CH_W-1:0]   LAST_CH  = CH_W'(NUM_CH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] mem_ptr_q, mem_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CH_W-1:0]   ch_sel_q, ch_sel_d;
    logic              busy_q, busy_d;
    logic              frame_done_q, frame_done_d;
    logic              wr_en;
    logic [DATA_W-1:0] fifo_q [FIFO_DEPTH];

    logic              full, empty, push, pop;
    logic              in_rtr_c;
    logic [NUM_CH-1:0] out_rts_c;

    // Ready/valid are decoded from registered state only, so no in->out combinational path.
    assign full      = (count_q == FULL_CNT);
    assign empty     = (count_q == '0);
    assign in_rtr_c  = (state_q == FETCH) && !full;
    assign out_rts_c = empty ? '0 : (NUM_CH'(1) << ch_sel_q);
    assign push      = bus.in_rts & in_rtr_c;
    assign pop       = |(out_rts_c & bus.out_rtr);

    assign bus.in_rtr   = in_rtr_c;
    assign bus.out_rts  = out_rts_c;
    assign bus.mem_ptr  = mem_ptr_q;
    assign bus.out_data = fifo_q[rd_ptr_q];
    assign busy         = busy_q;
    assign frame_done   = frame_done_q;

    always_comb begin
        state_d      = state_q;
        mem_ptr_d    = mem_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        ch_sel_d     = ch_sel_q;
        frame_done_d = 1'b0;
        wr_en        = 1'b0;

        if (en) begin
            // Start or restart: anything transferred this cycle is discarded.
            state_d   = FETCH;
            mem_ptr_d = '0;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
            ch_sel_d  = '0;
        end else begin
            if (push) begin
                wr_en    = 1'b1;
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
                if (mem_ptr_q == LAST_PTR) begin
                    mem_ptr_d = '0;
                    state_d   = DRAIN;
                end else begin
                    mem_ptr_d = mem_ptr_q + ADDR_W'(1);
                end
            end

            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
                ch_sel_d = (ch_sel_q == LAST_CH) ? '0 : ch_sel_q + CH_W'(1);
            end

            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase

            if ((state_q == DRAIN) && pop && (count_q == CNT_W'(1))) begin
                state_d      = IDLE;
                ch_sel_d     = '0;
                frame_done_d = 1'b1;
            end
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q      <= IDLE;
            mem_ptr_q    <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            ch_sel_q     <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_ptr_q    <= mem_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            ch_sel_q     <= ch_sel_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) fifo_q[i] <= '0;
        end else if (wr_en) begin
            fifo_q[wr_ptr_q] <= bus.in_data;
        end
    end
endmodule

// File: doc/multi_chan_fetch.md
Name: multi_chan_fetch

Overview:
- Parametrised successor to the single-frame RGB fetch unit.
- Streams FRAME_WORDS words from a memory port addressed by mem_ptr into an internal FIFO of depth FIFO_DEPTH.
- Deals FIFO words round-robin to NUM_CH downstream channels over per-channel rts/rtr handshakes.
- Adds frame-length wrap, restart-on-enable, FIFO decoupling, busy and frame_done status.

Parameters:
- DATA_W, 32, width of fetched words and out_data.
- ADDR_W, 17, width of mem_ptr.
- NUM_CH, 3, number of output channels (>=1); channel 0 = first word of a frame.
- FIFO_DEPTH, 4, FIFO entries; power of two, >=2.
- FRAME_WORDS, 76800, words per frame; 1 <= FRAME_WORDS <= 2^ADDR_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst_  in  1  asynchronous active-low reset.
- en  in  1  start/restart strobe, sampled on clk.
- in_data  in  DATA_W  memory word at address mem_ptr.
- in_rts  in  1  source has valid in_data.
- in_rtr  out  1  block accepts in_data this cycle.
- mem_ptr  out  ADDR_W  address of the next word to fetch.
- out_data  out  DATA_W  FIFO head word, shared by all channels.
- out_rts  out  NUM_CH  one-hot: the selected channel has valid data.
- out_rtr  in  NUM_CH  per-channel ready.
- busy  out  1  high in FETCH or DRAIN.
- frame_done  out  1  one-cycle pulse when the last frame word leaves the block.

Behaviour:
- Reset (async, rst_=0): state=IDLE, mem_ptr=0, FIFO empty, ch_sel=0, in_rtr=0, out_rts=0, busy=0, frame_done=0. Outputs hold these values while rst_ is low. out_data is don't-care while the FIFO is empty.
- States:
  - IDLE: waits for en=1, then moves to FETCH.
  - FETCH: accepts input words.
  - DRAIN: all FRAME_WORDS words fetched; empties the FIFO.
- Input transfer occurs when in_rts & in_rtr on a rising edge.
  - in_rtr = (state==FETCH) & !full. It is combinational from registers and never depends on in_rts.
  - On transfer: in_data is pushed and mem_ptr increments.
  - If mem_ptr==FRAME_WORDS-1 at transfer: mem_ptr wraps to 0 and state goes to DRAIN in the same edge.
- Output transfer on channel k occurs when out_rts[k] & out_rtr[k].
  - out_rts[k] = !empty & (ch_sel==k).
  - out_rtr of non-selected channels is ignored.
  - On transfer: pop, and ch_sel = (ch_sel==NUM_CH-1) ? 0 : ch_sel+1.
- Latency: a word pushed at edge t appears on out_data with out_rts asserted after edge t, i.e. usable at edge t+1. There is no same-cycle bypass, so an empty FIFO gives no combinational path from in_data to out_data.
- Simultaneous push and pop is allowed when the FIFO is neither empty nor full; occupancy is unchanged.
- Full: in_rtr=0, no push, mem_ptr holds.
- Empty: out_rts=0.
- Read and write pointers wrap modulo FIFO_DEPTH.
- Full/empty are tracked by an occupancy count of width clog2(FIFO_DEPTH)+1.
- Frame completion: in DRAIN, the pop that empties the FIFO asserts frame_done for exactly the next cycle. The same edge sets state=IDLE and ch_sel=0.
- Restart: en=1 in FETCH or DRAIN flushes everything on that edge.
  - FIFO emptied, mem_ptr=0, ch_sel=0, state=FETCH.
  - Any push or pop in that same cycle is discarded.
  - frame_done is not asserted.
- en=1 in IDLE starts a frame. en held high restarts every cycle; sources must pulse it.
- FRAME_WORDS=1: the first transfer moves directly to DRAIN with mem_ptr back at 0.
- busy = (state!=IDLE).
- Reset mid-frame: immediate return to reset values; no frame_done.

Test Plan:
- Reset, then en pulse with memory[i]=i+0x100, all out_rtr=1, NUM_CH=3, FRAME_WORDS=6 → channels receive 0x100/0x103 (ch0), 0x101/0x104 (ch1), 0x102/0x105 (ch2) in that order. frame_done pulses once, one cycle after the 6th pop; busy=0 afterwards; mem_ptr=0.
- out_rtr=0 for all channels, in_rts=1 → exactly FIFO_DEPTH=4 words accepted, in_rtr=0, mem_ptr=4. Raising out_rtr[0] only pops one word (0x100), then out_rts moves to ch1 and stalls.
- Steady state with all out_rtr=1 and in_rts=1 → one push and one pop per cycle; occupancy constant at 1; mem_ptr increments every cycle.
- en pulse at mem_ptr=3 with 2 words queued → next cycle FIFO empty, mem_ptr=0, out_rts=0, state FETCH. The next output is 0x100 on ch0, with no frame_done.
- rst_ asserted asynchronously mid-DRAIN → outputs go to reset values without a clock edge; no frame_done.
- FRAME_WORDS=1, NUM_CH=1 → single word 0x100 delivered on ch0; frame_done pulses; state returns to IDLE.
